// File: rtl/sound_pkg.sv
// sound_pkg: shared sound types, cue note frequencies and priority helpers.
package sound_pkg;

   typedef enum logic {OFF = 1'b0, ON = 1'b1} MODE_TYPES;
   typedef enum logic [1:0] {CUE_NONE, CUE_EAT, CUE_WIN, CUE_CRASH} cue_t;
   typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} seq_state_t;

   localparam logic [8:0] F_G4  = 9'd392;
   localparam logic [8:0] F_B4  = 9'd494;
   localparam logic [8:0] F_C4  = 9'd262;
   localparam logic [8:0] F_E4  = 9'd330;
   localparam logic [8:0] F_C5  = 9'd511;  // 523 Hz does not fit in 9 bits
   localparam logic [8:0] F_DS4 = 9'd311;
   localparam logic [8:0] F_AS3 = 9'd233;
   localparam logic [8:0] F_DS3 = 9'd156;

   function automatic cue_t top_cue(input logic [2:0] v);
      return v[2] ? CUE_CRASH : v[1] ? CUE_WIN : v[0] ? CUE_EAT : CUE_NONE;
   endfunction

   function automatic logic [2:0] cue_bit(input cue_t c);
      return c == CUE_EAT ? 3'b001 : c == CUE_WIN ? 3'b010 : c == CUE_CRASH ? 3'b100 : 3'b000;
   endfunction

endpackage

// File: rtl/sound_cue_rom.sv
// sound_cue_rom: combinational note table giving frequency and note count per cue.
module sound_cue_rom
   import sound_pkg::*;
(
   input  cue_t        cue,
   input  logic [1:0]  idx,
   output logic [8:0]  freq,
   output logic [2:0]  count
);

   always_comb begin
      freq = 9'd0;
      count = 3'd0;
      case (cue)
         CUE_EAT: begin
            count = 3'd2;
            freq = idx[0] ? F_B4 : F_G4;
         end
         CUE_WIN: begin
            count = 3'd4;
            freq = idx == 2'd0 ? F_C4 : idx == 2'd1 ? F_E4 : idx == 2'd2 ? F_G4 : F_C5;
         end
         CUE_CRASH: begin
            count = 3'd3;
            freq = idx == 2'd0 ? F_DS4 : idx == 2'd1 ? F_AS3 : F_DS3;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: arbitrates cue requests by priority and sequences each cue's
// notes as timed TONE/GAP phases for the square-wave oscillator.
module sound_sequencer
   import sound_pkg::*;
#(
   parameter int unsigned NOTE_TICKS = 1_000_000,
   parameter int unsigned GAP_TICKS  = 200_000
)
(
   input  logic       clk,
   input  logic       rst,
   input  MODE_TYPES  sound_en,
   input  logic       req_eat,
   input  logic       req_win,
   input  logic       req_crash,
   output logic [8:0] freq,
   output MODE_TYPES  osc_state,
   output logic       playSound,
   output logic       busy,
   output cue_t       cue_id
);

   localparam logic [23:0] NOTE_LAST = 24'(NOTE_TICKS - 1);
   localparam logic [23:0] GAP_LAST  = 24'(GAP_TICKS - 1);

   seq_state_t  state, n_state;
   cue_t        n_cue, arr, nxt;
   logic [1:0]  idx, n_idx;
   logic [23:0] timer, n_timer;
   logic [2:0]  pend, n_pend, reqs, avail;
   logic        last;
   logic [8:0]  rom_freq;
   logic [2:0]  rom_count;

   assign reqs  = {req_crash, req_win, req_eat};
   assign avail = pend | reqs;
   assign arr   = top_cue(reqs);
   assign nxt   = top_cue(avail);

   always_comb begin
      n_state = state;
      n_cue = cue_id;
      n_idx = idx;
      n_timer = timer + 24'd1;
      n_pend = avail;
      if (sound_en == OFF) begin
         n_state = S_IDLE;
         n_cue = CUE_NONE;
         n_idx = 2'd0;
         n_timer = 24'd0;
         n_pend = 3'd0;
      end else if (state == S_IDLE) begin
         n_timer = 24'd0;
         if (nxt != CUE_NONE) begin
            n_state = S_TONE;
            n_cue = nxt;
            n_idx = 2'd0;
            n_pend = avail & ~cue_bit(nxt);
         end
      end else if (arr > cue_id) begin
         // preempted cue is dropped, not re-queued
         n_state = S_TONE;
         n_cue = arr;
         n_idx = 2'd0;
         n_timer = 24'd0;
         n_pend = avail & ~cue_bit(arr);
      end else if (state == S_TONE && timer == NOTE_LAST) begin
         n_state = S_GAP;
         n_timer = 24'd0;
      end else if (state == S_GAP && timer == GAP_LAST) begin
         n_timer = 24'd0;
         if (!last) begin
            n_state = S_TONE;
            n_idx = idx + 2'd1;
         end else begin
            n_state = nxt == CUE_NONE ? S_IDLE : S_TONE;
            n_cue = nxt;
            n_idx = 2'd0;
            n_pend = avail & ~cue_bit(nxt);
         end
      end
   end

   sound_cue_rom rom (
      .cue   (n_cue),
      .idx   (n_idx),
      .freq  (rom_freq),
      .count (rom_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cue_id <= CUE_NONE;
         idx <= 2'd0;
         timer <= 24'd0;
         pend <= 3'd0;
         last <= 1'b0;
         freq <= 9'd0;
         osc_state <= OFF;
         playSound <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= n_state;
         cue_id <= n_cue;
         idx <= n_idx;
         timer <= n_timer;
         pend <= n_pend;
         last <= {1'b0, n_idx} == rom_count - 3'd1;
         freq <= n_state == S_TONE ? rom_freq : n_state == S_GAP ? freq : 9'd0;
         osc_state <= n_state == S_TONE ? ON : OFF;
         playSound <= n_state == S_TONE;
         busy <= n_state != S_IDLE;
      end
   end

endmodule
